tmr_fault_monitor: RTL

- Sits beside the NFC voters and consumes the same three replica output buses (A/B/C) that feed them.
- Per cycle, finds which replica is in the minority and filters transients with a persistence counter.
- Declares a replica failed, masks it, then runs the remaining pair in duplex compare.
- Raises a sticky uncorrectable-error flag when the surviving pair disagrees. Gives the system a fault report and a mask for later replica exclusion or resync.

---
 rtl/tmr_mon_pkg.sv | 27 ++
 rtl/tmr_replica_tracker.sv | 57 +++++
 rtl/tmr_fault_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tmr_mon_pkg.sv
// tmr_mon_pkg: shared constants for the TMR fault monitor.
//   state_e        : monitor state encoding (NORMAL / DEGRADED / FAILED)
//   REP_A/B/C      : replica indices used for masks and per-replica arrays
//   persist_legal  : elaboration-time range check for the PERSIST parameter
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAILED   = 2'd2
  } state_e;

  localparam int REP_A   = 0;
  localparam int REP_B   = 1;
  localparam int REP_C   = 2;
  localparam int NUM_REP = 3;

  // Run counters only ever need to reach PERSIST, so 4 bits cover the legal range.
  localparam int PERSIST_MIN = 1;
  localparam int PERSIST_MAX = 15;
  localparam int RUN_W       = 4;

  function automatic bit persist_legal(input int p);
    return (p >= PERSIST_MIN) && (p <= PERSIST_MAX);
  endfunction

endpackage

// File: rtl/tmr_replica_tracker.sv
// tmr_replica_tracker: per-replica persistence filter and lifetime error count.
//   clk, rst        : clock, synchronous active-low reset
//   i_en            : sample enable; 0 holds all state
//   i_min           : this replica is in the minority this cycle
//   i_mask          : replica already declared failed
//   i_clr           : software clear (run counter only)
//   o_persist_hit   : this enabled sample completes a run of PERSIST minority cycles
//   o_err_cnt       : saturating count of minority cycles (reset-only clear)
module tmr_replica_tracker
  import tmr_mon_pkg::*;
#(
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_min,
  input  logic             i_mask,
  input  logic             i_clr,
  output logic             o_persist_hit,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [RUN_W-1:0] P_SAT = RUN_W'(PERSIST);

  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_active;

  assign w_active = i_en & ~i_mask & i_min;

  // Hit when this sample brings the run to PERSIST (or it is already saturated).
  assign o_persist_hit = w_active && (r_run >= (P_SAT - RUN_W'(1)));
  assign o_err_cnt     = r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run     <= '0;
      r_err_cnt <= '0;
    end else begin
      // Lifetime count ignores mask and clr: it is the exclusion/resync evidence.
      if (i_en && i_min && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_W'(1);

      if (i_clr || i_mask)
        r_run <= '0;
      else if (i_en) begin
        if (!i_min)
          r_run <= '0;
        else if (r_run != P_SAT)
          r_run <= r_run + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: watches the three replica buses feeding the voters,
// masks a persistently-minority replica, then duplex-compares the survivors.
//   clk, rst         : clock, synchronous active-low reset
//   en               : sample enable; 0 holds all state
//   rep_a/b/c        : replica output buses
//   clr              : software clear of fault state (err counts kept)
//   fault_mask       : bit0=A, bit1=B, bit2=C declared failed (sticky)
//   state            : 0=NORMAL, 1=DEGRADED, 2=FAILED
//   tmr_error        : sticky uncorrectable error
//   fault_irq        : one-cycle pulse on a fault-driven state change
//   err_cnt_a/b/c    : saturating minority-cycle counts per replica
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH   = 27,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] rep_a,
  input  logic [WIDTH-1:0] rep_b,
  input  logic [WIDTH-1:0] rep_c,
  input  logic             clr,
  output logic [2:0]       fault_mask,
  output logic [1:0]       state,
  output logic             tmr_error,
  output logic             fault_irq,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  if (!persist_legal(PERSIST)) begin : g_bad_persist
    $error("tmr_fault_monitor: PERSIST out of range 1..15");
  end

  logic [NUM_REP-1:0][WIDTH-1:0] w_rep;
  logic [NUM_REP-1:0][CNT_W-1:0] w_err_cnt;
  logic [NUM_REP-1:0]            w_min;
  logic [NUM_REP-1:0]            w_hit;
  logic [1:0]                    w_hit_cnt;
  logic                          w_surv_diff;

  state_e             r_state, w_state_nxt;
  logic [NUM_REP-1:0] r_mask,  w_mask_nxt;
  logic               r_err,   w_err_nxt;
  logic               r_irq,   w_irq_nxt;

  assign w_rep = {rep_c, rep_b, rep_a};

  for (genvar g = 0; g < NUM_REP; g++) begin : g_trk
    // Minority: disagrees with both other replicas on at least one bit.
    assign w_min[g] = |((w_rep[g] ^ w_rep[(g+1)%NUM_REP]) &
                        (w_rep[g] ^ w_rep[(g+2)%NUM_REP]));

    tmr_replica_tracker #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
    ) u_trk (
      .clk           (clk),
      .rst           (rst),
      .i_en          (en),
      .i_min         (w_min[g]),
      .i_mask        (r_mask[g]),
      .i_clr         (clr),
      .o_persist_hit (w_hit[g]),
      .o_err_cnt     (w_err_cnt[g])
    );
  end

  assign w_hit_cnt = {1'b0, w_hit[REP_A]} + {1'b0, w_hit[REP_B]} + {1'b0, w_hit[REP_C]};

  // Duplex compare of the two unmasked replicas; only meaningful in DEGRADED,
  // where exactly one mask bit is set.
  always_comb begin
    w_surv_diff = 1'b0;
    if (r_mask[REP_A])
      w_surv_diff = |(rep_b ^ rep_c);
    else if (r_mask[REP_B])
      w_surv_diff = |(rep_a ^ rep_c);
    else
      w_surv_diff = |(rep_a ^ rep_b);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err;
    w_irq_nxt   = 1'b0;
    if (clr) begin
      // Clear beats any detection in the same cycle.
      w_state_nxt = ST_NORMAL;
      w_mask_nxt  = '0;
      w_err_nxt   = 1'b0;
    end else if (en) begin
      unique case (r_state)
        ST_NORMAL: begin
          if (w_hit_cnt == 2'd1) begin
            w_mask_nxt  = r_mask | w_hit;
            w_state_nxt = ST_DEGRADED;
            w_irq_nxt   = 1'b1;
          end else if (w_hit_cnt >= 2'd2) begin
            w_mask_nxt  = r_mask | w_hit;
            w_state_nxt = ST_FAILED;
            w_err_nxt   = 1'b1;
            w_irq_nxt   = 1'b1;
          end
        end
        ST_DEGRADED: begin
          if (w_surv_diff) begin
            w_state_nxt = ST_FAILED;
            w_err_nxt   = 1'b1;
            w_irq_nxt   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_NORMAL;
      r_mask  <= '0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_err   <= w_err_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign fault_mask = r_mask;
  assign state      = r_state;
  assign tmr_error  = r_err;
  assign fault_irq  = r_irq;
  assign err_cnt_a  = w_err_cnt[REP_A];
  assign err_cnt_b  = w_err_cnt[REP_B];
  assign err_cnt_c  = w_err_cnt[REP_C];

endmodule
